concat_fifo_ctrl: RTL and testbench

Parametrised successor to the fixed 128x512 concat FIFO wrapper. It provides a synchronous single-clock FIFO on inferred RAM (no vendor IP) with configurable width and depth, and a selectable read mode (standard or first-word-fall-through). It keeps the registered producer/consumer threshold flags, and adds a soft flush, full/count outputs and sticky overflow/underflow error flags. It sits between the conv/pool writer and the concat reader in the TJPU datapath.

---
 rtl/tjpu_fifo_pkg.sv | 11 +
 rtl/fifo_sdp_ram.sv | 31 +++
 rtl/concat_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_concat_fifo_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tjpu_fifo_pkg.sv
// Shared constants and helpers for the TJPU FIFO blocks.
package tjpu_fifo_pkg;

    localparam int unsigned FIFO_MODE_STD  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    function automatic int unsigned cnt_w(input int unsigned addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no array reset.
module fifo_sdp_ram #(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/concat_fifo_ctrl.sv
// Single-clock FIFO between the conv/pool writer and the concat reader, with
// standard or first-word-fall-through read, burst threshold flags and sticky errors.
module concat_fifo_ctrl
    import tjpu_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 128,
    parameter int unsigned ADDR_BITS = 9,
    parameter int unsigned FWFT      = FIFO_MODE_STD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     din,
    input  logic                 wr_en,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     dout,
    output logic                 empty,
    output logic                 full,
    output logic [ADDR_BITS:0]   data_count,
    input  logic [ADDR_BITS:0]   m_count,
    output logic                 m_ready,
    input  logic [ADDR_BITS:0]   s_count,
    output logic                 s_ready,
    output logic                 overflow,
    output logic                 underflow
);

    localparam int unsigned CW      = cnt_w(ADDR_BITS);
    localparam bit          IS_FWFT = (FWFT == FIFO_MODE_FWFT);

    localparam logic [CW-1:0]        DEPTH_C = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [CW:0]          DEPTH_X = {2'b01, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d, ram_words;
    logic                 empty_q, empty_d, full_q, full_d;
    logic                 head_vld_q, head_vld_d;
    logic                 m_ready_q, m_ready_d, s_ready_q, s_ready_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d;
    logic                 flush, wr_acc, rd_acc, ram_wr, ram_rd;
    logic [WIDTH-1:0]     ram_rdata;

    always_comb begin
        flush     = rst | clr;
        wr_acc    = wr_en & ~full_q;
        rd_acc    = rd_en & ~empty_q;
        ram_words = count_q - {{(CW-1){1'b0}}, head_vld_q};
        ram_wr    = wr_acc;

        // The RAM read register doubles as the head stage. In FWFT mode it is
        // refilled whenever it is empty or being popped; in standard mode
        // head_vld only records that dout has been loaded at least once.
        if (IS_FWFT) begin
            ram_rd     = (ram_words != '0) & (~head_vld_q | rd_acc);
            head_vld_d = ram_rd | (head_vld_q & ~rd_acc);
        end else begin
            ram_rd     = rd_acc;
            head_vld_d = head_vld_q | rd_acc;
        end

        wr_ptr_d  = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = ram_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d   = count_q + {{(CW-1){1'b0}}, wr_acc} - {{(CW-1){1'b0}}, rd_acc};
        empty_d   = IS_FWFT ? ~head_vld_d : (count_d == '0);
        full_d    = (count_d == DEPTH_C);
        m_ready_d = (count_q >= m_count);
        // One extra bit so count + s_count cannot wrap.
        s_ready_d = ({1'b0, count_q} + {1'b0, s_count}) <= DEPTH_X;
        ovf_d     = ovf_q | (wr_en & full_q);
        unf_d     = unf_q | (rd_en & empty_q);

        if (flush) begin
            ram_wr     = 1'b0;
            ram_rd     = 1'b0;
            head_vld_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            empty_d    = 1'b1;
            full_d     = 1'b0;
            m_ready_d  = 1'b0;
            s_ready_d  = 1'b1;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q   <= wr_ptr_d;
        rd_ptr_q   <= rd_ptr_d;
        count_q    <= count_d;
        empty_q    <= empty_d;
        full_q     <= full_d;
        head_vld_q <= head_vld_d;
        m_ready_q  <= m_ready_d;
        s_ready_q  <= s_ready_d;
        ovf_q      <= ovf_d;
        unf_q      <= unf_d;
    end

    fifo_sdp_ram #(
        .WIDTH     (WIDTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr_q),
        .wr_data (din),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rdata)
    );

    assign dout       = head_vld_q ? ram_rdata : '0;
    assign empty      = empty_q;
    assign full       = full_q;
    assign data_count = count_q;
    assign m_ready    = m_ready_q;
    assign s_ready    = s_ready_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_concat_fifo_ctrl.sv
// Directed bench: a standard-mode and an FWFT instance share stimulus; each vector
// names the instance it checks.
module tb_concat_fifo_ctrl;

    localparam int unsigned W  = 16;
    localparam int unsigned AB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic [W-1:0]  din = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [AB:0]   m_count = 5'd5;
    logic [AB:0]   s_count = 5'd12;

    logic [W-1:0]  s_dout, f_dout;
    logic          s_empty, s_full, s_mr, s_sr, s_ovf, s_unf;
    logic          f_empty, f_full, f_mr, f_sr, f_ovf, f_unf;
    logic [AB:0]   s_cnt, f_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    concat_fifo_ctrl #(.WIDTH(W), .ADDR_BITS(AB), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(s_dout), .empty(s_empty), .full(s_full), .data_count(s_cnt),
        .m_count(m_count), .m_ready(s_mr), .s_count(s_count), .s_ready(s_sr),
        .overflow(s_ovf), .underflow(s_unf)
    );

    concat_fifo_ctrl #(.WIDTH(W), .ADDR_BITS(AB), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .clr(clr), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(f_dout), .empty(f_empty), .full(f_full), .data_count(f_cnt),
        .m_count(m_count), .m_ready(f_mr), .s_count(s_count), .s_ready(f_sr),
        .overflow(f_ovf), .underflow(f_unf)
    );

    typedef struct {
        logic          rs, cl, wr, rd;
        logic [W-1:0]  din;
        logic          f;
        logic [AB:0]   cnt;
        logic          emp, ful, ovf, unf;
        logic          cd;
        logic [W-1:0]  dq;
        logic          ct, mr, sr;
    } vec_t;

    vec_t vq[$];

    function automatic void push(input logic rs, cl, wr, rd, input logic [W-1:0] d,
                                 input logic f, input logic [AB:0] cnt,
                                 input logic emp, ful, ovf, unf,
                                 input logic cd = 1'b0, input logic [W-1:0] dq = '0,
                                 input logic ct = 1'b0, input logic mr = 1'b0,
                                 input logic sr = 1'b0);
        vec_t v;
        v.rs = rs; v.cl = cl; v.wr = wr; v.rd = rd; v.din = d; v.f = f;
        v.cnt = cnt; v.emp = emp; v.ful = ful; v.ovf = ovf; v.unf = unf;
        v.cd = cd; v.dq = dq; v.ct = ct; v.mr = mr; v.sr = sr;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        push(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1);
        // Fill 16, drop 17th, drain in order
        for (int i = 1; i <= 16; i++)
            push(0, 0, 1, 0, W'(i), 0, 5'(i), 0, (i == 16), 0, 0);
        push(0, 0, 1, 0, 16'h11, 0, 16, 0, 1, 1, 0);
        for (int i = 1; i <= 16; i++)
            push(0, 0, 0, 1, 0, 0, 5'(16 - i), (i == 16), 0, 1, 0, 1, W'(i));
        // Thresholds with m_count=5, s_count=12
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1);
        for (int i = 1; i <= 5; i++)
            push(0, 0, 1, 0, 16'h20 + W'(i), 0, 5'(i), 0, 0, 0, 0, 0, 0, 1, 0, 1);
        push(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        push(0, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0, 1, 16'h21, 1, 1, 0);
        push(0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0, 1, 16'h21, 1, 0, 1);
        // Simultaneous access at full and at count 7
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 16; i++)
            push(0, 0, 1, 0, 16'h40 + W'(i), 0, 5'(i + 1), 0, (i == 15), 0, 0);
        push(0, 0, 1, 1, 16'h99, 0, 15, 0, 0, 1, 0, 1, 16'h40);
        for (int i = 1; i <= 8; i++)
            push(0, 0, 0, 1, 0, 0, 5'(15 - i), 0, 0, 1, 0, 1, 16'h40 + W'(i));
        push(0, 0, 1, 1, 16'h77, 0, 7, 0, 0, 1, 0, 1, 16'h49);
        for (int i = 10; i <= 15; i++)
            push(0, 0, 0, 1, 0, 0, 5'(16 - i), 0, 0, 1, 0, 1, 16'h40 + W'(i));
        push(0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1, 16'h77);
        // clr at count 9 with a concurrent write
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++)
            push(0, 0, 1, 0, 16'h50 + W'(i), 0, 5'(i + 1), 0, 0, 0, 0);
        push(0, 1, 1, 0, 16'hEE, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1);
        for (int i = 1; i <= 3; i++)
            push(0, 0, 1, 0, 16'h60 + W'(i), 0, 5'(i), 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++)
            push(0, 0, 0, 1, 0, 0, 5'(3 - i), (i == 3), 0, 0, 0, 1, 16'h60 + W'(i));
        // Underflow is sticky; rst clears everything
        push(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 16'h63);
        push(0, 0, 1, 0, 16'h71, 0, 1, 0, 0, 0, 1);
        push(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1, 16'h71);
        push(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 1);
        // FWFT: single word falls through two cycles after the write
        push(0, 0, 1, 0, 16'hAB, 1, 1, 1, 0, 0, 0, 1, 0);
        push(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 16'hAB);
        push(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 16'hAB);
        push(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            push(0, 0, 1, 0, 16'hB0 + W'(i), 1, 5'(i + 1), (i == 0), 0, 0, 0,
                 (i != 0), 16'hB0);
        for (int i = 0; i < 8; i++)
            push(0, 0, 0, 1, 0, 1, 5'(7 - i), (i == 7), 0, 0, 0,
                 (i != 7), 16'hB1 + W'(i));
        push(0, 0, 0, 1, 0, 1, 0, 1, 0, 0, 1);

        foreach (vq[k]) begin
            logic [W-1:0] a_dout;
            logic [AB:0]  a_cnt;
            logic         a_emp, a_ful, a_ovf, a_unf, a_mr, a_sr;
            rst = vq[k].rs; clr = vq[k].cl; wr_en = vq[k].wr; rd_en = vq[k].rd;
            din = vq[k].din;
            step();
            if (vq[k].f) begin
                a_dout = f_dout; a_cnt = f_cnt; a_emp = f_empty; a_ful = f_full;
                a_ovf = f_ovf; a_unf = f_unf; a_mr = f_mr; a_sr = f_sr;
            end else begin
                a_dout = s_dout; a_cnt = s_cnt; a_emp = s_empty; a_ful = s_full;
                a_ovf = s_ovf; a_unf = s_unf; a_mr = s_mr; a_sr = s_sr;
            end
            chk("count", k, 32'(a_cnt), 32'(vq[k].cnt));
            chk("empty", k, 32'(a_emp), 32'(vq[k].emp));
            chk("full", k, 32'(a_ful), 32'(vq[k].ful));
            chk("overflow", k, 32'(a_ovf), 32'(vq[k].ovf));
            chk("underflow", k, 32'(a_unf), 32'(vq[k].unf));
            if (vq[k].cd) chk("dout", k, 32'(a_dout), 32'(vq[k].dq));
            if (vq[k].ct) begin
                chk("m_ready", k, 32'(a_mr), 32'(vq[k].mr));
                chk("s_ready", k, 32'(a_sr), 32'(vq[k].sr));
            end
        end

        // Threshold corners: m_count = 0, s_count > DEPTH, then both at DEPTH
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        m_count = 5'd0; s_count = 5'd17;
        step();
        chk("rst_m_ready", 0, 32'(s_mr), 32'd0);
        chk("rst_s_ready", 0, 32'(s_sr), 32'd1);
        rst = 1'b0;
        step();
        chk("m0_m_ready", 1, 32'(s_mr), 32'd1);
        chk("s17_s_ready", 1, 32'(s_sr), 32'd0);
        chk("m0_m_ready_fwft", 1, 32'(f_mr), 32'd1);
        chk("s17_s_ready_fwft", 1, 32'(f_sr), 32'd0);
        m_count = 5'd16; s_count = 5'd16;
        step();
        chk("m16_m_ready", 2, 32'(s_mr), 32'd0);
        chk("s16_s_ready", 2, 32'(s_sr), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
